product_bcd_display: RTL and testbench

Downstream display stage for the 4x4 array multiplier: accepts the 8-bit product, converts it to three BCD digits with a sequential shift-and-add-3 (double-dabble) engine, and drives three active-low seven-segment displays. It sits between the multiplier's product bus and the board's HEX0–HEX2 pins. It also exposes the packed BCD result for other consumers.

---
 rtl/product_bcd_display_pkg.sv | 33 +++
 rtl/product_bcd_display_if.sv | 29 ++
 rtl/product_bcd_display_hex_to_seven_seg.sv | 27 ++
 rtl/product_bcd_display.sv | 152 +++++++++++++++
 tb/tb_product_bcd_display.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/product_bcd_display_pkg.sv
// Shared types and constants for the product BCD display stage:
// FSM states, active-low seven-segment codes and the double-dabble nibble adjust.
package product_bcd_display_pkg;

  localparam int unsigned BcdDigits   = 3;
  localparam int unsigned NibbleWidth = 4;
  localparam int unsigned BcdWidth    = BcdDigits * NibbleWidth;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Active-low segments ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Pre-shift correction; nibbles never exceed 9, so +3 cannot carry out.
  function automatic logic [NibbleWidth-1:0] dd_adjust(input logic [NibbleWidth-1:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/product_bcd_display_if.sv
// Product-in / BCD-and-segments-out bundle for product_bcd_display.
// master drives PRODUCT/IN_VALID; slave is the display stage.
interface product_bcd_display_if
  import product_bcd_display_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0]    PRODUCT;
  logic                IN_VALID;
  logic                IN_READY;
  logic [BcdWidth-1:0] BCD;
  logic                DONE;
  logic                BUSY;
  logic [6:0]          HEX0;
  logic [6:0]          HEX1;
  logic [6:0]          HEX2;

  modport master (
    output PRODUCT, IN_VALID,
    input  IN_READY, BCD, DONE, BUSY, HEX0, HEX1, HEX2
  );

  modport slave (
    input  PRODUCT, IN_VALID,
    output IN_READY, BCD, DONE, BUSY, HEX0, HEX1, HEX2
  );

endinterface

// File: rtl/product_bcd_display_hex_to_seven_seg.sv
// Combinational 4-bit digit to active-low seven-segment decoder.
// Codes above 9 cannot occur in BCD and decode to blank.
module hex_to_seven_seg
  import product_bcd_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/product_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter driving three seven-segment digits.
// Optional leading-zero blanking on HEX1/HEX2: PRODUCT_BCD_LEADING_ZERO_BLANK_EN.
module product_bcd_display
  import product_bcd_display_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                  CLOCK_50,
  input logic                  RESET,
  product_bcd_display_if.slave bus_io
);

  localparam int unsigned        CntWidth   = $clog2(WIDTH);
  localparam int unsigned        ShiftWidth = BcdWidth + WIDTH;
  localparam logic [CntWidth-1:0] LastCnt   = CntWidth'(WIDTH - 1);

`ifdef PRODUCT_BCD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LeadRst = SEG_BLANK;
`else
  localparam logic [6:0] LeadRst = SEG_0;
`endif

  state_e                state_q, state_d;
  logic [ShiftWidth-1:0] shift_q, shift_d, shift_shl;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [BcdWidth-1:0]   bcd_q, bcd_d, bcd_adj, bcd_next;
  logic [6:0]            hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
  logic [6:0]            seg0, seg1, seg2;
  logic                  in_ready, busy, done;
  logic                  accept;

  assign accept = in_ready && bus_io.IN_VALID;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (cnt_q == LastCnt) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs; RESET forces IN_READY low so a same-cycle IN_VALID is dropped
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = !RESET;
      StShift: busy     = 1'b1;
      StDone:  done     = 1'b1;
      default: ;
    endcase
  end

  // One double-dabble iteration: correct every nibble, then shift the whole register
  always_comb begin
    for (int unsigned i = 0; i < BcdDigits; i++) begin
      bcd_adj[i*NibbleWidth +: NibbleWidth] =
          dd_adjust(shift_q[WIDTH + i*NibbleWidth +: NibbleWidth]);
    end
  end

  assign shift_shl = {bcd_adj, shift_q[WIDTH-1:0]} << 1;
  assign bcd_next  = shift_shl[ShiftWidth-1 -: BcdWidth];

  hex_to_seven_seg u_dec0 (
    .digit_i (bcd_next[3:0]),
    .seg_o   (seg0)
  );

  hex_to_seven_seg u_dec1 (
    .digit_i (bcd_next[7:4]),
    .seg_o   (seg1)
  );

  hex_to_seven_seg u_dec2 (
    .digit_i (bcd_next[11:8]),
    .seg_o   (seg2)
  );

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    hex0_d  = hex0_q;
    hex1_d  = hex1_q;
    hex2_d  = hex2_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = ShiftWidth'(bus_io.PRODUCT);
          cnt_d   = '0;
        end
      end
      StShift: begin
        shift_d = shift_shl;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          bcd_d  = bcd_next;
          hex0_d = seg0;
`ifdef PRODUCT_BCD_LEADING_ZERO_BLANK_EN
          hex1_d = (bcd_next[11:4] == 8'h00) ? SEG_BLANK : seg1;
          hex2_d = (bcd_next[11:8] == 4'h0)  ? SEG_BLANK : seg2;
`else
          hex1_d = seg1;
          hex2_d = seg2;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      shift_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      hex0_q  <= SEG_0;
      hex1_q  <= LeadRst;
      hex2_q  <= LeadRst;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
    end
  end

  assign bus_io.IN_READY = in_ready;
  assign bus_io.BUSY     = busy;
  assign bus_io.DONE     = done;
  assign bus_io.BCD      = bcd_q;
  assign bus_io.HEX0     = hex0_q;
  assign bus_io.HEX1     = hex1_q;
  assign bus_io.HEX2     = hex2_q;

endmodule

// File: tb/tb_product_bcd_display.sv
// Directed bench for product_bcd_display: reset, fixed products, full sweep,
// back-to-back handshake and reset during a conversion.
module tb_product_bcd_display;

  logic clk = 1'b0;
  logic rst;
  int   vec_count = 0;
  int   err_count = 0;

  always #5 clk = ~clk;

`ifdef PRODUCT_BCD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LeadRst = 7'h7F;
`else
  localparam logic [6:0] LeadRst = 7'h40;
`endif

  product_bcd_display_if #(.WIDTH(8)) bus ();

  product_bcd_display #(.WIDTH(8)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus_io   (bus)
  );

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_hex2(input int h);
`ifdef PRODUCT_BCD_LEADING_ZERO_BLANK_EN
    if (h == 0) return 7'h7F;
`endif
    return seg_ref(h);
  endfunction

  function automatic logic [6:0] exp_hex1(input int h, input int t);
`ifdef PRODUCT_BCD_LEADING_ZERO_BLANK_EN
    if (h == 0 && t == 0) return 7'h7F;
`endif
    return seg_ref(t);
  endfunction

  // Waits for IN_READY, accepts p, then waits (bounded) for DONE.
  // lat is 1 on the accept edge and counts each later edge.
  task automatic run_conv(input logic [7:0] p, output int lat, output bit seen);
    int guard = 0;
    @(negedge clk);
    bus.PRODUCT  = p;
    bus.IN_VALID = 1'b1;
    while (!bus.IN_READY && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.DONE) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.IN_VALID = 1'b1;
    bus.PRODUCT  = 8'd77;
    repeat (3) @(posedge clk);
    #1;
    vec_count++;
    if (bus.IN_READY !== 1'b0) begin
      err_count++; $display("FAIL reset_ready: got %b want 0", bus.IN_READY);
    end
    vec_count++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      err_count++; $display("FAIL reset_busy_done: got %b%b want 00", bus.BUSY, bus.DONE);
    end
    vec_count++;
    if (bus.BCD !== 12'h000) begin
      err_count++; $display("FAIL reset_bcd: got %h want 000", bus.BCD);
    end
    vec_count++;
    if (bus.HEX0 !== 7'h40 || bus.HEX1 !== LeadRst || bus.HEX2 !== LeadRst) begin
      err_count++;
      $display("FAIL reset_hex: got %h %h %h want %h %h 40", bus.HEX2, bus.HEX1, bus.HEX0,
               LeadRst, LeadRst);
    end
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    rst          = 1'b0;
    @(posedge clk);
    #1;
    vec_count++;
    if (bus.IN_READY !== 1'b1 || bus.BUSY !== 1'b0) begin
      err_count++;
      $display("FAIL post_reset_idle: got ready=%b busy=%b want 1 0", bus.IN_READY, bus.BUSY);
    end
  endtask

  task automatic test_225();
    int lat;
    bit seen;
    run_conv(8'd225, lat, seen);
    vec_count++;
    if (!seen || lat != 9) begin
      err_count++; $display("FAIL lat_225: got seen=%0b lat=%0d want 1 9", seen, lat);
    end
    vec_count++;
    if (bus.BCD !== 12'h225) begin
      err_count++; $display("FAIL bcd_225: got %h want 225", bus.BCD);
    end
    vec_count++;
    if (bus.HEX2 !== 7'h24 || bus.HEX1 !== 7'h24 || bus.HEX0 !== 7'h12) begin
      err_count++;
      $display("FAIL hex_225: got %h %h %h want 24 24 12", bus.HEX2, bus.HEX1, bus.HEX0);
    end
    repeat (3) @(posedge clk);
    #1;
    vec_count++;
    if (bus.BCD !== 12'h225 || bus.DONE !== 1'b0 || bus.HEX0 !== 7'h12) begin
      err_count++;
      $display("FAIL hold_225: got bcd=%h done=%b hex0=%h want 225 0 12", bus.BCD, bus.DONE,
               bus.HEX0);
    end
  endtask

  task automatic test_42();
    int lat;
    bit seen;
    logic [6:0] want2;
`ifdef PRODUCT_BCD_LEADING_ZERO_BLANK_EN
    want2 = 7'h7F;
`else
    want2 = 7'h40;
`endif
    run_conv(8'd42, lat, seen);
    vec_count++;
    if (!seen || bus.BCD !== 12'h042) begin
      err_count++; $display("FAIL bcd_42: got seen=%0b bcd=%h want 1 042", seen, bus.BCD);
    end
    vec_count++;
    if (bus.HEX2 !== want2 || bus.HEX1 !== 7'h19 || bus.HEX0 !== 7'h24) begin
      err_count++;
      $display("FAIL hex_42: got %h %h %h want %h 19 24", bus.HEX2, bus.HEX1, bus.HEX0, want2);
    end
  endtask

  task automatic test_zero();
    int lat;
    bit seen;
    run_conv(8'd0, lat, seen);
    vec_count++;
    if (!seen || bus.BCD !== 12'h000) begin
      err_count++; $display("FAIL bcd_0: got seen=%0b bcd=%h want 1 000", seen, bus.BCD);
    end
    vec_count++;
    if (bus.HEX2 !== LeadRst || bus.HEX1 !== LeadRst || bus.HEX0 !== 7'h40) begin
      err_count++;
      $display("FAIL hex_0: got %h %h %h want %h %h 40", bus.HEX2, bus.HEX1, bus.HEX0,
               LeadRst, LeadRst);
    end
  endtask

  task automatic test_255();
    int lat;
    bit seen;
    run_conv(8'd255, lat, seen);
    vec_count++;
    if (!seen || bus.BCD !== 12'h255) begin
      err_count++; $display("FAIL bcd_255: got seen=%0b bcd=%h want 1 255", seen, bus.BCD);
    end
    vec_count++;
    if (bus.HEX2 !== 7'h24 || bus.HEX1 !== 7'h12 || bus.HEX0 !== 7'h12) begin
      err_count++;
      $display("FAIL hex_255: got %h %h %h want 24 12 12", bus.HEX2, bus.HEX1, bus.HEX0);
    end
  endtask

  task automatic test_sweep();
    int lat;
    bit seen;
    int h, t, o;
    logic [11:0] want;
    for (int v = 0; v < 256; v++) begin
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      want = {4'(h), 4'(t), 4'(o)};
      run_conv(8'(v), lat, seen);
      vec_count++;
      if (!seen || bus.BCD !== want) begin
        err_count++;
        $display("FAIL sweep_bcd %0d: got seen=%0b bcd=%h want 1 %h", v, seen, bus.BCD, want);
      end
      vec_count++;
      if (bus.HEX2 !== exp_hex2(h) || bus.HEX1 !== exp_hex1(h, t) || bus.HEX0 !== seg_ref(o))
      begin
        err_count++;
        $display("FAIL sweep_hex %0d: got %h %h %h want %h %h %h", v, bus.HEX2, bus.HEX1,
                 bus.HEX0, exp_hex2(h), exp_hex1(h, t), seg_ref(o));
      end
    end
  endtask

  task automatic test_back_to_back();
    int          acc[$];
    logic [11:0] res[$];
    int          bad   = 0;
    int          guard = 0;
    bit          rdy;
    @(negedge clk);
    bus.PRODUCT  = 8'd9;
    bus.IN_VALID = 1'b1;
    while (!bus.IN_READY && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int c = 0; c < 30; c++) begin
      rdy = bus.IN_READY;
      @(posedge clk);
      #1;
      if (rdy && bus.IN_VALID) begin
        acc.push_back(c);
        if (acc.size() == 1) bus.PRODUCT = 8'd100;
        else bus.IN_VALID = 1'b0;
      end
      if (bus.DONE) res.push_back(bus.BCD);
      if (bus.BUSY && bus.IN_READY) bad++;
      @(negedge clk);
    end
    bus.IN_VALID = 1'b0;
    vec_count++;
    if (acc.size() != 2) begin
      err_count++; $display("FAIL b2b_accepts: got %0d want 2", acc.size());
    end else begin
      vec_count++;
      if (acc[1] - acc[0] != 10) begin
        err_count++; $display("FAIL b2b_spacing: got %0d want 10", acc[1] - acc[0]);
      end
    end
    vec_count++;
    if (res.size() != 2) begin
      err_count++; $display("FAIL b2b_results: got %0d want 2", res.size());
    end else begin
      vec_count++;
      if (res[0] !== 12'h009 || res[1] !== 12'h100) begin
        err_count++; $display("FAIL b2b_values: got %h %h want 009 100", res[0], res[1]);
      end
    end
    vec_count++;
    if (bad != 0) begin
      err_count++; $display("FAIL b2b_ready_in_shift: got %0d cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    int dones = 0;
    @(negedge clk);
    bus.PRODUCT  = 8'd200;
    bus.IN_VALID = 1'b1;
    while (!bus.IN_READY && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.DONE) dones++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vec_count++;
    if (bus.IN_READY !== 1'b0) begin
      err_count++; $display("FAIL mid_reset_ready: got %b want 0", bus.IN_READY);
    end
    @(posedge clk);
    #1;
    if (bus.DONE) dones++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vec_count++;
    if (bus.IN_READY !== 1'b1 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      err_count++;
      $display("FAIL mid_reset_flags: got ready=%b busy=%b done=%b want 1 0 0", bus.IN_READY,
               bus.BUSY, bus.DONE);
    end
    vec_count++;
    if (bus.BCD !== 12'h000) begin
      err_count++; $display("FAIL mid_reset_bcd: got %h want 000", bus.BCD);
    end
    vec_count++;
    if (bus.HEX0 !== 7'h40 || bus.HEX1 !== LeadRst || bus.HEX2 !== LeadRst) begin
      err_count++;
      $display("FAIL mid_reset_hex: got %h %h %h want %h %h 40", bus.HEX2, bus.HEX1, bus.HEX0,
               LeadRst, LeadRst);
    end
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.DONE) dones++;
    end
    vec_count++;
    if (dones != 0) begin
      err_count++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", dones);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.PRODUCT  = '0;
    test_reset();
    test_225();
    test_42();
    test_zero();
    test_255();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
